// File: rtl/axis_ofmap_unload_fifo.sv
// axis_ofmap_unload_fifo
// Buffers wide MAC-array result words (MAC_NUM lanes x 5 bits) in a small
// FIFO and serializes each word onto an AXI4-Stream master, six lanes
// (30 bits) per beat, raising tlast on the final beat of each tile.
//
// Handshakes (both sides strict valid/ready):
//   - input side : a word is taken on a rising edge where
//                  ofmaps_valid & ofmaps_ready; ofmaps_ready may be high
//                  while full when the head word is leaving that cycle.
//   - output side: a beat transfers on a rising edge where
//                  m_axis_tvalid & m_axis_tready; tvalid/tdata/tlast come
//                  only from registered state, so they hold while stalled.
module axis_ofmap_unload_fifo #(
  parameter int C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int MAC_NUM                = 256,
  parameter int AXIS_UNLOAD_FIFO_DEPTH = 4,
  parameter int bit_num                = $clog2(AXIS_UNLOAD_FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [5*MAC_NUM-1:0]            ofmaps_in,
  input  logic                            ofmaps_valid,
  output logic                            ofmaps_ready,
  input  logic [11:0]                     output_channel_size,
  input  logic [15:0]                     words_per_tile,
  input  logic                            axis_clear,
  output logic [bit_num:0]                fifo_cnt,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            tile_done
);

  localparam int               LW         = 5 * MAC_NUM;
  localparam logic [bit_num:0] DEPTH_CNT  = (bit_num + 1)'(AXIS_UNLOAD_FIFO_DEPTH);
  localparam logic [11:0]      MAC_NUM_12 = 12'(MAC_NUM);

  logic [LW-1:0]      mem_q [AXIS_UNLOAD_FIFO_DEPTH];
  logic [bit_num-1:0] rd_ptr_q, rd_ptr_d;
  logic [bit_num-1:0] wr_ptr_q, wr_ptr_d;
  logic [bit_num:0]   cnt_q, cnt_d;
  logic [8:0]         lane_cnt_q, lane_cnt_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic               tile_done_q, tile_done_d;

  logic [11:0]        n_eff;
  logic               last_beat;
  logic               beat;
  logic               pop;
  logic               push;
  logic               tlast;
  logic [LW-1:0]      rd_word;
  logic [29:0]        beat_lanes;

  // Channel size 0 or beyond the array width means "all lanes".
  assign n_eff = (output_channel_size == 12'd0 || output_channel_size > MAC_NUM_12)
                 ? MAC_NUM_12 : output_channel_size;

  assign last_beat     = ({3'b000, lane_cnt_q} + 12'd6) >= n_eff;
  assign m_axis_tvalid = (cnt_q != '0);
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign pop           = beat & last_beat;
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_full     = (cnt_q == DEPTH_CNT);
  assign ofmaps_ready  = ~fifo_full | pop;
  assign push          = ofmaps_valid & ofmaps_ready;
  assign fifo_cnt      = cnt_q;
  assign tile_done     = tile_done_q;
  assign rd_word       = mem_q[rd_ptr_q];

  // Lane selection for the current beat. n_eff never exceeds MAC_NUM, so
  // the single bound also blanks lanes past the end of the array.
  for (genvar k = 0; k < 6; k++) begin : g_lane
    logic [11:0] lane_idx;
    assign lane_idx = {3'b000, lane_cnt_q} + 12'(k);
    assign beat_lanes[5*k +: 5] = (lane_idx < n_eff)
                                  ? 5'(rd_word >> (lane_idx * 12'd5)) : 5'd0;
  end

  assign tlast = m_axis_tvalid & last_beat & (words_per_tile != 16'd0)
                 & (word_cnt_q == (words_per_tile - 16'd1));

  assign m_axis_tlast = tlast;
  assign m_axis_tdata = m_axis_tvalid ? C_M_AXIS_TDATA_WIDTH'(beat_lanes) : '0;

  // Next-state for pointers, occupancy, beat position and tile counter.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    lane_cnt_d  = lane_cnt_q;
    word_cnt_d  = word_cnt_q;
    tile_done_d = beat & tlast;
    if (axis_clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      lane_cnt_d  = '0;
      word_cnt_d  = '0;
      tile_done_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (beat) lane_cnt_d = last_beat ? 9'd0 : lane_cnt_q + 9'd6;
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        word_cnt_d = tlast ? 16'd0 : word_cnt_q + 16'd1;
      end
      if (push & ~pop)      cnt_d = cnt_q + 1'b1;
      else if (pop & ~push) cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      lane_cnt_q  <= '0;
      word_cnt_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      lane_cnt_q  <= lane_cnt_d;
      word_cnt_q  <= word_cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Word storage; a flush leaves contents alone and drops the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AXIS_UNLOAD_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !axis_clear) begin
      mem_q[wr_ptr_q] <= ofmaps_in;
    end
  end

endmodule

// File: tb/tb_axis_ofmap_unload_fifo.sv
// Testbench for axis_ofmap_unload_fifo: directed scenarios followed by
// randomized traffic, all checked against a word/beat-level reference model.
module tb_axis_ofmap_unload_fifo;

  localparam int MAC_NUM = 256;
  localparam int DEPTH   = 4;
  localparam int WW      = 5 * MAC_NUM;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] ofmaps_in;
  logic          ofmaps_valid;
  logic          ofmaps_ready;
  logic [11:0]   output_channel_size;
  logic [15:0]   words_per_tile;
  logic          axis_clear;
  logic [2:0]    fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          tile_done;

  always #5 clk = ~clk;

  axis_ofmap_unload_fifo #(
    .C_M_AXIS_TDATA_WIDTH  (32),
    .MAC_NUM               (MAC_NUM),
    .AXIS_UNLOAD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ofmaps_in          (ofmaps_in),
    .ofmaps_valid       (ofmaps_valid),
    .ofmaps_ready       (ofmaps_ready),
    .output_channel_size(output_channel_size),
    .words_per_tile     (words_per_tile),
    .axis_clear         (axis_clear),
    .fifo_cnt           (fifo_cnt),
    .fifo_empty         (fifo_empty),
    .fifo_full          (fifo_full),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .tile_done          (tile_done)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds every beat still owed by the DUT as {tlast, tdata}.
  logic [32:0]  exp_q[$];
  logic [31:0]  beat_log[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           m_n;          // effective lanes per word
  int           m_b;          // beats per word
  int           m_wpt;        // words per tile
  int           tile_word;    // position of next pushed word within its tile
  bit           exp_td;       // expected tile_done on the next sample
  int           valid_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int ocs, input int wpt);
    output_channel_size = 12'(ocs);
    words_per_tile      = 16'(wpt);
    m_n   = (ocs == 0 || ocs > MAC_NUM) ? MAC_NUM : ocs;
    m_b   = (m_n + 5) / 6;
    m_wpt = wpt;
  endtask

  // Expand an accepted word into its expected beats.
  task automatic add_word(input logic [WW-1:0] w);
    logic [31:0] d;
    bit          last;
    int          l;
    for (int b = 0; b < m_b; b++) begin
      d = '0;
      for (int k = 0; k < 6; k++) begin
        l = b * 6 + k;
        if (l < m_n) d[5*k +: 5] = w[5*l +: 5];
      end
      last = (b == m_b - 1) && (m_wpt != 0) && (tile_word == m_wpt - 1);
      exp_q.push_back({last, d});
    end
    if (m_wpt != 0) tile_word = (tile_word + 1) % m_wpt;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [WW-1:0] ramp_word();
    logic [WW-1:0] w;
    for (int i = 0; i < MAC_NUM; i++) w[5*i +: 5] = 5'(i);
    return w;
  endfunction

  // ---------------- driver: one clock cycle, entered at a falling edge ----------------
  task automatic cycle(input bit want_push, input logic [WW-1:0] w, input bit rdy, input bit clr);
    int          sz;
    int          cnt;
    bit          beat;
    bit          pop_w;
    bit          mready;
    logic [32:0] e;
    sz  = exp_q.size();
    cnt = (sz + m_b - 1) / m_b;
    check("tvalid", m_axis_tvalid, sz != 0);
    check("fifo_cnt", fifo_cnt, cnt);
    check("fifo_empty", fifo_empty, cnt == 0);
    check("fifo_full", fifo_full, cnt == DEPTH);
    check("tile_done", tile_done, exp_td);
    if (sz != 0) begin
      e = exp_q[0];
      check("tdata", m_axis_tdata, e[31:0]);
      check("tlast", m_axis_tlast, e[32]);
    end else begin
      check("idle_tdata", m_axis_tdata, 0);
      check("idle_tlast", m_axis_tlast, 0);
    end
    if (m_axis_tvalid) valid_cycles++;

    m_axis_tready = rdy;
    axis_clear    = clr;
    beat   = (sz != 0) && rdy;
    pop_w  = beat && ((sz - 1) % m_b == 0);
    mready = (cnt < DEPTH) || pop_w;
    exp_td = 1'b0;
    if (beat) begin
      e = exp_q.pop_front();
      beat_log.push_back(m_axis_tdata);
      exp_td = e[32] && !clr;
    end
    #1;
    if (!clr) check("ofmaps_ready", ofmaps_ready, mready);
    ofmaps_valid = want_push;
    ofmaps_in    = w;
    if (clr) begin
      exp_q.delete();
      tile_word = 0;
    end else if (want_push && mready) begin
      add_word(w);
    end
    @(negedge clk);
    ofmaps_valid = 1'b0;
    axis_clear   = 1'b0;
  endtask

  task automatic do_clear();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vc0;
    int ns[7] = '{1, 5, 7, 12, 30, 255, 300};

    rst = 1'b1;
    ofmaps_valid = 1'b0;
    ofmaps_in = '0;
    m_axis_tready = 1'b0;
    axis_clear = 1'b0;
    tile_word = 0;
    exp_td = 1'b0;
    set_cfg(16, 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ofmaps_ready", ofmaps_ready, 1);
    check("rst_tdata", m_axis_tdata, 0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Two words of 16 lanes, tile of 2, always ready.
    beat_log.delete();
    cycle(1'b1, ramp_word(), 1'b1, 1'b0);
    cycle(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);
    check("s1_beat0", beat_log[0], 32'h0A418820);

    // Same traffic with tready toggling 1,0,0,1.
    do_clear();
    set_cfg(16, 2);
    for (int i = 0; i < 30; i++)
      cycle(i < 2, (i == 0) ? ramp_word() : rand_word(), (i % 4 == 0) || (i % 4 == 3), 1'b0);

    // Fill while stalled, overflow attempt, then push through the pop cycle.
    do_clear();
    set_cfg(16, 2);
    repeat (5) cycle(1'b1, rand_word(), 1'b0, 1'b0);
    repeat (20) cycle(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b0);

    // Channel size 0 means all 256 lanes: 43 beats, tlast on the last.
    do_clear();
    set_cfg(0, 1);
    vc0 = valid_cycles;
    cycle(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (46) cycle(1'b0, '0, 1'b1, 1'b0);
    check("n256_beats", valid_cycles - vc0, 43);

    // Flush in the middle of a word, then restart a fresh tile.
    do_clear();
    set_cfg(30, 3);
    cycle(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
    do_clear();
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, right after a tlast beat.
    do_clear();
    set_cfg(6, 1);
    cycle(1'b1, rand_word(), 1'b1, 1'b0);
    cycle(1'b1, rand_word(), 1'b1, 1'b0);
    check("pre_rst_tile_done", tile_done, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tvalid", m_axis_tvalid, 0);
    check("rst_async_tlast", m_axis_tlast, 0);
    check("rst_async_tdata", m_axis_tdata, 0);
    check("rst_async_tile_done", tile_done, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    tile_word = 0;
    exp_td = 1'b0;
    @(negedge clk);
    check("post_rst_fifo_empty", fifo_empty, 1);
    check("post_rst_ofmaps_ready", ofmaps_ready, 1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic over several channel sizes and tile lengths.
    foreach (ns[i]) begin
      do_clear();
      set_cfg(ns[i], $urandom_range(0, 4));
      repeat (250)
        cycle(1'($urandom_range(0, 1)), rand_word(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_ofmap_unload_fifo.md
Name: axis_ofmap_unload_fifo

Overview:
- Transmit-side counterpart of the ifmap preload path.
- Buffers wide MAC-array result words (5 bits per lane, MAC_NUM lanes) in a small FIFO, then serializes each word onto an AXI4-Stream master at 6 lanes (30 bits) per 32-bit beat.
- Generates tlast at the end of each tile.
- Sits between the MAC array output and the output DMA.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, AXIS data width; only 32 is supported.
- MAC_NUM, 256, number of 5-bit lanes per wide word.
- AXIS_UNLOAD_FIFO_DEPTH, 4, number of wide-word entries; must be a power of 2, ≥2.
- bit_num, clogb2(AXIS_UNLOAD_FIFO_DEPTH-1), pointer width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ofmaps_in  in  5*MAC_NUM  wide result word; lane i = bits [5i+4:5i].
- ofmaps_valid  in  1  push request.
- ofmaps_ready  out  1  push accepted this cycle = ~fifo_full | pop.
- output_channel_size  in  12  valid lanes per word; 0 or >MAC_NUM means MAC_NUM. Must be stable while fifo is non-empty.
- words_per_tile  in  16  words per tile; 0 means tlast is never asserted.
- axis_clear  in  1  synchronous flush; highest priority after rst.
- fifo_cnt  out  bit_num+1  occupied entries.
- fifo_empty  out  1  fifo_cnt==0.
- fifo_full  out  1  fifo_cnt==AXIS_UNLOAD_FIFO_DEPTH.
- m_axis_tdata  out  32  beat data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of tile.
- tile_done  out  1  one-cycle pulse, one cycle after the tlast handshake.

Behaviour:
- Reset values: all FIFO entries 0; rd_ptr, wr_ptr, fifo_cnt, lane_cnt (9 bit), word_cnt (16 bit) all 0. Outputs: fifo_empty=1, fifo_full=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, tile_done=0, ofmaps_ready=1.
- Reset asserted mid-stream aborts immediately; partial word and tile are discarded.
- beat = m_axis_tvalid & m_axis_tready.
- Let N = effective channel size. last_beat_of_word = (lane_cnt+6 >= N).
- pop = beat & last_beat_of_word.
- push = ofmaps_valid & (~fifo_full | pop). On push: write ofmaps_in to entry wr_ptr, then wr_ptr+1 (wraps mod depth). Push when full without pop is ignored and the data is lost; the producer must honour ofmaps_ready.
- fifo_cnt:
  - push&pop: unchanged.
  - push only: +1.
  - pop only: -1.
  - Push into an empty FIFO is not visible at the output until the next cycle (no fall-through).
- m_axis_tvalid = ~fifo_empty, combinational from registers.
- m_axis_tdata, when tvalid:
  - bits [5k+4:5k] for k=0..5 = lane (lane_cnt+k) of entry rd_ptr.
  - A lane with index ≥N or ≥MAC_NUM drives 0.
  - bits [31:30] = 0.
  - When tvalid=0, tdata=0.
- tdata and tlast must hold stable while tvalid & ~tready. This is guaranteed because they derive only from registered state.
- On beat:
  - lane_cnt ← last_beat_of_word ? 0 : lane_cnt+6.
  - On pop: rd_ptr+1 (wraps mod depth).
- Beats per word = ceil(N/6); N=256 gives 43 beats.
- m_axis_tlast = tvalid & last_beat_of_word & (words_per_tile≠0) & (word_cnt == words_per_tile-1).
- On pop: word_cnt ← tlast ? 0 : word_cnt+1.
- tile_done registered: 1 in the cycle after a beat with tlast=1, else 0.
- axis_clear: next cycle rd_ptr, wr_ptr, fifo_cnt, lane_cnt, word_cnt = 0 and tile_done = 0; FIFO contents are not cleared.
  - Push and beat in the clear cycle are discarded; tvalid drops the next cycle.
  - Issuing clear while tvalid&~tready is an accepted protocol abort.
- Latency: push at cycle t gives the first beat valid at t+1.

Test Plan:
- DEPTH=4, N=16, words_per_tile=2, tready=1. Push words W0 (lane i=i[4:0]) and W1 → 6 beats total. Beat0 tdata=0x0A418820 (lanes 0-5 = 0,1,2,3,4,5). Beat2 carries lanes 12-15 with bits [29:20]=0. tlast only on beat5. tile_done=1 one cycle later. fifo_cnt returns to 0.
- Same stimulus with tready toggling 1,0,0,1 → tdata/tlast stable in all stalled cycles. Beat order and values identical to scenario 1.
- tready=0, push 4 words → fifo_full=1, ofmaps_ready=0, a 5th push is ignored. Then tready=1: on the cycle of the final beat of word0, ofmaps_ready=1, a push is accepted, and fifo_cnt stays 4.
- N=0 (treated as 256), words_per_tile=1, one word pushed → 43 beats. Beat42 = lanes 252-255 in bits [19:0], bits [31:20]=0, tlast=1.
- words_per_tile=3. After 4 beats of word0 (N=30), assert axis_clear → next cycle tvalid=0, fifo_cnt=0. A new word pushed afterwards restarts at lane 0 with word_cnt=0.
- Assert rst for 1 cycle asynchronously (between edges) mid-beat → tvalid, tlast, tdata, tile_done = 0 immediately. fifo_empty=1 and ofmaps_ready=1 after release.
